// File: rtl/round_key_store_dec_pkg.sv
// round_key_store_dec_pkg
// Shared AES definitions for the decryption round-key store: FSM state
// enumeration, the AES-128 round count and GF(2^8) arithmetic helpers used
// by InvMixColumns.
package round_key_store_dec_pkg;

  localparam int unsigned AES128_NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    READY,
    DRAIN
  } rks_state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/round_key_store_dec_inv_mix_columns.sv
// inv_mix_columns_key
// Purely combinational AES InvMixColumns applied to a round key, used to build
// the equivalent-inverse-cipher key schedule. Column c occupies bits
// [BLOCK_LENGTH-1-32c -: 32], byte 0 of the column being the most significant.
// Ports:
//   key_in   input  BLOCK_LENGTH  untransformed round key
//   key_out  output BLOCK_LENGTH  InvMixColumns(key_in)
module inv_mix_columns_key
  import round_key_store_dec_pkg::*;
#(
  parameter int unsigned BLOCK_LENGTH = 128
) (
  input  logic [BLOCK_LENGTH-1:0] key_in,
  output logic [BLOCK_LENGTH-1:0] key_out
);

  localparam int unsigned NUM_COLS = BLOCK_LENGTH / 32;

  function automatic logic [7:0] col_byte(input logic [BLOCK_LENGTH-1:0] k,
                                          input int unsigned c,
                                          input int unsigned i);
    return k[BLOCK_LENGTH-1-32*c-8*i -: 8];
  endfunction

  always_comb begin
    key_out = '0;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        key_out[BLOCK_LENGTH-1-32*c-8*i -: 8] =
            gf_mul(8'h0e, col_byte(key_in, c, i))
          ^ gf_mul(8'h0b, col_byte(key_in, c, (i + 1) % 4))
          ^ gf_mul(8'h0d, col_byte(key_in, c, (i + 2) % 4))
          ^ gf_mul(8'h09, col_byte(key_in, c, (i + 3) % 4));
      end
    end
  end

endmodule

// File: rtl/round_key_store_dec.sv
// round_key_store_dec
// Captures a forward AES key schedule from an upstream generator and replays
// it in reverse round order to a decryption datapath.
// Build option: RKS_EQ_INV_CIPHER_EN -- when defined, rounds 1..NUM_ROUNDS-1
// are output through InvMixColumns (equivalent inverse cipher).
// Ports:
//   clk, rst             clock; synchronous active-low reset
//   load, run            start fill / start reverse drain (pulses)
//   gen_en, gen_round    request to upstream generator
//   key_in, key_in_valid upstream key, one cycle after its request
//   key_out, key_out_round, key_out_valid, key_out_ready  downstream handshake
//   sched_ready          complete schedule stored, idle
//   done                 pulse after round 0 accepted downstream
module round_key_store_dec
  import round_key_store_dec_pkg::*;
#(
  parameter int unsigned BLOCK_LENGTH = 128,
  parameter int unsigned NUM_ROUNDS   = AES128_NUM_ROUNDS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    run,
  output logic                    gen_en,
  output logic [3:0]              gen_round,
  input  logic [BLOCK_LENGTH-1:0] key_in,
  input  logic                    key_in_valid,
  output logic [BLOCK_LENGTH-1:0] key_out,
  output logic [3:0]              key_out_round,
  output logic                    key_out_valid,
  input  logic                    key_out_ready,
  output logic                    sched_ready,
  output logic                    done
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  rks_state_e state, state_nxt;

  logic [3:0] wr_idx;
  logic [3:0] rd_idx;
  logic [3:0] iss_idx;
  logic       iss_done;

  logic [BLOCK_LENGTH-1:0] slots [NUM_ROUNDS+1];
  logic [BLOCK_LENGTH-1:0] slot_rd;
  logic [BLOCK_LENGTH-1:0] key_sel;

  logic capture;
  logic accept;

  assign capture = (state == FILL) && key_in_valid;
  assign accept  = (state == DRAIN) && key_out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (load) state_nxt = FILL;
      FILL:  if (capture && wr_idx == LAST) state_nxt = READY;
      READY: begin
        if (load)     state_nxt = FILL;
        else if (run) state_nxt = DRAIN;
      end
      DRAIN: if (accept && rd_idx == '0) state_nxt = READY;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      wr_idx   <= '0;
      rd_idx   <= '0;
      iss_idx  <= '0;
      iss_done <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= accept && (rd_idx == '0);

      if (state != FILL && state_nxt == FILL) begin
        wr_idx   <= '0;
        iss_idx  <= '0;
        iss_done <= 1'b0;
      end else if (state == FILL) begin
        // Issue and capture run independently: capture lags issue by the
        // generator latency, so iss_idx and wr_idx are separate counters.
        if (gen_en) begin
          if (iss_idx == LAST) iss_done <= 1'b1;
          else                 iss_idx  <= iss_idx + 4'd1;
        end
        if (capture && wr_idx != LAST) wr_idx <= wr_idx + 4'd1;
      end

      if (state == READY && state_nxt == DRAIN)
        rd_idx <= LAST;
      else if (accept && rd_idx != '0)
        rd_idx <= rd_idx - 4'd1;
    end
  end

  // Storage is not reset; validity is tracked by the FSM alone.
  always_ff @(posedge clk) begin
    if (rst && capture) slots[wr_idx] <= key_in;
  end

  assign slot_rd = slots[rd_idx];

`ifdef RKS_EQ_INV_CIPHER_EN
  logic [BLOCK_LENGTH-1:0] slot_imc;

  inv_mix_columns_key #(.BLOCK_LENGTH(BLOCK_LENGTH)) u_imc (
    .key_in  (slot_rd),
    .key_out (slot_imc)
  );

  assign key_sel = (rd_idx != '0 && rd_idx != LAST) ? slot_imc : slot_rd;
`else
  assign key_sel = slot_rd;
`endif

  always_comb begin
    gen_en        = 1'b0;
    gen_round     = '0;
    key_out_valid = 1'b0;
    key_out_round = '0;
    key_out       = '0;
    sched_ready   = 1'b0;
    case (state)
      FILL: begin
        gen_en    = !iss_done;
        gen_round = iss_done ? 4'd0 : iss_idx;
      end
      READY: sched_ready = 1'b1;
      DRAIN: begin
        key_out_valid = 1'b1;
        key_out_round = rd_idx;
        key_out       = key_sel;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_round_key_store_dec.sv
// tb_round_key_store_dec
// Self-checking bench: a model AES-128 key generator feeds the store, and the
// reverse drain is compared with a reference key expansion computed here.
// Honours RKS_EQ_INV_CIPHER_EN the same way as the design.
module tb_round_key_store_dec;

  localparam int N  = 10;
  localparam int BL = 128;

  logic          clk = 1'b0;
  logic          rst, load, run, key_out_ready, key_in_valid;
  logic [BL-1:0] key_in;
  logic          gen_en, key_out_valid, sched_ready, done;
  logic [3:0]    gen_round, key_out_round;
  logic [BL-1:0] key_out;

  always #5 clk = ~clk;

  round_key_store_dec #(.BLOCK_LENGTH(BL), .NUM_ROUNDS(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .load          (load),
    .run           (run),
    .gen_en        (gen_en),
    .gen_round     (gen_round),
    .key_in        (key_in),
    .key_in_valid  (key_in_valid),
    .key_out       (key_out),
    .key_out_round (key_out_round),
    .key_out_valid (key_out_valid),
    .key_out_ready (key_out_ready),
    .sched_ready   (sched_ready),
    .done          (done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [BL-1:0] obs, input logic [BL-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  logic [BL-1:0] rk [0:N];

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int unsigned p = 0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (int'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (32'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] s;
    for (int y = 1; y < 256; y++) if (ref_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    s = 8'h63;
    for (int r = 0; r < 5; r++) s = s ^ ((inv << r) | (inv >> (8 - r)));
    return s;
  endfunction

  task automatic set_key(input logic [BL-1:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {ref_sbox(t[31:24]) ^ rcon, ref_sbox(t[23:16]), ref_sbox(t[15:8]), ref_sbox(t[7:0])};
        rcon = ref_mul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= N; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [BL-1:0] ref_imc(input logic [BL-1:0] k);
    logic [BL-1:0] o;
    logic [7:0]    a [4];
    logic [7:0]    m [4];
    m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = k[127-32*c-8*i -: 8];
      for (int i = 0; i < 4; i++) begin
        o[127-32*c-8*i -: 8] = 8'h00;
        for (int j = 0; j < 4; j++)
          o[127-32*c-8*i -: 8] = o[127-32*c-8*i -: 8] ^ ref_mul(m[(j - i + 4) % 4], a[j]);
      end
    end
    return o;
  endfunction

  function automatic logic [BL-1:0] exp_key(input int r);
`ifdef RKS_EQ_INV_CIPHER_EN
    if (r != 0 && r != N) return ref_imc(rk[r]);
`endif
    return rk[r];
  endfunction

  function automatic logic [BL-1:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- model upstream generator ----------------
  logic       pend_v = 1'b0;
  logic [3:0] pend_r = '0;
  logic       noise_on = 1'b0;

  always @(negedge clk) begin
    pend_v = gen_en;
    pend_r = gen_round;
  end

  // Noise exercises key_in_valid outside FILL, which must not alter the store.
  always @(posedge clk) begin
    #1;
    if (pend_v) begin
      key_in       = (pend_r <= 4'(N)) ? rk[pend_r] : rand_key();
      key_in_valid = 1'b1;
    end else begin
      key_in       = rand_key();
      key_in_valid = noise_on && ($urandom % 2 == 1);
    end
  end

  // ---------------- sequences ----------------
  task automatic do_fill(input bit with_run);
    int cnt = 0, gaps = 0, guard = 0;
    noise_on = 1'b0;
    @(negedge clk);
    load = 1'b1; run = with_run;
    @(negedge clk);
    load = 1'b0; run = 1'b0;
    if (with_run) check("ld_run_fill", {key_out_valid, gen_en}, 2'b01);
    while (!sched_ready && guard < 60) begin
      // load/run mid-FILL must be ignored
      load = (guard == 3);
      run  = (guard == 3);
      if (gen_en) begin
        check("gen_round", gen_round, cnt);
        cnt++;
      end else if (cnt < N + 1) gaps++;
      @(negedge clk);
      guard++;
    end
    load = 1'b0; run = 1'b0;
    check("fill_ready", sched_ready, 1);
    check("gen_cnt", cnt, N + 1);
    check("gen_gaps", gaps, 0);
    check("gen_en_idle", gen_en, 0);
    noise_on = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // stall_at >= 0: hold ready low 3 cycles at that round; rand_rdy: random ready
  task automatic do_drain(input int stall_at, input bit rand_rdy, input bit fips);
    int  exp_r = N, guard = 0, stall_left = 3;
    bit  rdy;
    @(negedge clk);
    run = 1'b1; key_out_ready = 1'b0;
    @(negedge clk);
    run = 1'b0;
    while (exp_r >= 0 && guard < 100) begin
      check("valid", key_out_valid, 1);
      check("round", key_out_round, exp_r);
      check("key", key_out, exp_key(exp_r));
      check("done_early", done, 0);
      if (fips && exp_r == N) check("fips_r10", key_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      if (fips && exp_r == 0) check("fips_r0", key_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);
`ifdef RKS_EQ_INV_CIPHER_EN
      if (fips && exp_r == 9) check("fips_r9_imc", key_out, ref_imc(128'hac7766f319fadc2128d12941575c006e));
`endif
      if (rand_rdy) rdy = ($urandom % 2 == 1);
      else if (exp_r == stall_at && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else rdy = 1'b1;
      key_out_ready = rdy;
      if (rdy) exp_r--;
      @(negedge clk);
      guard++;
    end
    key_out_ready = 1'b0;
    check("done_pulse", done, 1);
    check("ready_after", {sched_ready, key_out_valid}, 2'b10);
    @(negedge clk);
    check("done_once", done, 0);
  endtask

  task automatic drain_abort();
    int guard = 0;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    key_out_ready = 1'b1;
    while (key_out_round != 4'd5 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("abort_at_r5", key_out_round, 5);
    key_out_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("abort_out", {gen_en, gen_round, key_out_valid, key_out_round, sched_ready, done}, 0);
    check("abort_key", key_out, 0);
    rst = 1'b1;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (4) begin
      check("run_ignored", {key_out_valid, sched_ready}, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; run = 1'b0; key_out_ready = 1'b0;
    key_in = '0; key_in_valid = 1'b0;
    set_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    repeat (3) @(negedge clk);
    check("rst_ctl", {gen_en, gen_round, key_out_valid, key_out_round, sched_ready, done}, 0);
    check("rst_key", key_out, 0);
    rst = 1'b1;
    noise_on = 1'b1;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    check("idle_run", {key_out_valid, sched_ready}, 0);

    do_fill(1'b0);
    do_drain(7, 1'b0, 1'b1);
    do_drain(-1, 1'b0, 1'b1);
    do_drain(-1, 1'b1, 1'b1);

    set_key(rand_key());
    do_fill(1'b1);
    do_drain($urandom_range(0, N), 1'b0, 1'b0);
    do_drain(-1, 1'b1, 1'b0);

    drain_abort();

    set_key(rand_key());
    do_fill(1'b0);
    do_drain(-1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/round_key_store_dec.md
ROUND_KEY_STORE_DEC -- requirements
Module: round_key_store_dec

Interface
REQ-001 Parameter BLOCK_LENGTH, default 128, round-key width in bits.
REQ-002 Parameter NUM_ROUNDS, default 10, last round index; the store holds NUM_ROUNDS+1 keys.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 load  input  1  pulse that starts expansion and capture of a fresh key schedule.
REQ-006 run  input  1  pulse that starts a reverse-order drain of the stored schedule.
REQ-007 gen_en  output  1  enable to the upstream key generator.
REQ-008 gen_round  output  4  round index to the upstream key generator.
REQ-009 key_in  input  BLOCK_LENGTH  round key from the upstream generator.
REQ-010 key_in_valid  input  1  key_in valid; the upstream key arrives one cycle after its gen_en/gen_round.
REQ-011 key_out  output  BLOCK_LENGTH  round key to the decryption datapath.
REQ-012 key_out_round  output  4  round index of key_out.
REQ-013 key_out_valid  output  1  valid half of the downstream handshake.
REQ-014 key_out_ready  input  1  ready half of the downstream handshake.
REQ-015 sched_ready  output  1  high while a complete schedule is stored and no fill or drain is in progress.
REQ-016 done  output  1  one-cycle pulse after round 0 is accepted downstream.

Function
REQ-017 The FSM SHALL have four states: IDLE, FILL, READY and DRAIN.
REQ-018 IDLE: load moves to FILL; run is ignored.
REQ-019 FILL issue phase: gen_en SHALL be high for exactly NUM_ROUNDS+1 consecutive cycles, with gen_round = 0,1,...,NUM_ROUNDS.
REQ-020 FILL capture: each key_in_valid cycle writes key_in into slot wr_idx, then increments wr_idx from 0.
- The cycle after the capture into slot NUM_ROUNDS, the FSM moves to READY and sched_ready rises.
REQ-021 key_in_valid outside FILL SHALL be ignored; the store is unchanged.
REQ-022 READY with run: move to DRAIN with rd_idx = NUM_ROUNDS.
REQ-023 READY with load: move to FILL and overwrite the schedule.
REQ-024 READY with load and run in the same cycle: load wins.
REQ-025 DRAIN outputs:
- key_out_valid high.
- key_out = slot[rd_idx].
- key_out_round = rd_idx.
- key_out and key_out_round are held stable while key_out_valid is high and key_out_ready is low.
REQ-026 DRAIN on key_out_valid && key_out_ready: rd_idx decrements.
- If rd_idx is 0, done pulses the next cycle and the FSM returns to READY; the schedule is retained for replay.
REQ-027 load and run SHALL be ignored during FILL and DRAIN.
REQ-028 gen_en SHALL be low and key_out_valid SHALL be low in every state other than FILL and DRAIN respectively.
REQ-029 Index counters SHALL never wrap: wr_idx saturates at NUM_ROUNDS and rd_idx stops at 0.

Reset
REQ-030 While rst is low, the following SHALL take these values:
- FSM: IDLE.
- wr_idx, rd_idx: 0.
- gen_en, gen_round: 0.
- key_out_valid, key_out_round, key_out: 0.
- sched_ready, done: 0.
REQ-031 Reset asserted mid-FILL or mid-DRAIN SHALL abort the operation; the stored schedule is invalid until the next complete FILL.
- Storage contents need not be cleared.

Configuration
REQ-032 Macro RKS_EQ_INV_CIPHER_EN defined: key_out for rounds 1..NUM_ROUNDS-1 SHALL be InvMixColumns(slot[rd_idx]), for the equivalent inverse cipher.
- Rounds 0 and NUM_ROUNDS are output untransformed.
REQ-033 Macro RKS_EQ_INV_CIPHER_EN undefined: key_out SHALL always equal slot[rd_idx] unmodified.

Structure
REQ-034 The shared AES package SHALL hold:
- the FSM state enumeration;
- the AES-128 NUM_ROUNDS constant;
- GF(2^8) xtime/multiply functions, used by InvMixColumns.
REQ-035 InvMixColumns SHALL be a single combinational sub-module, inv_mix_columns_key, instantiated only under RKS_EQ_INV_CIPHER_EN.

Verification
REQ-036 Load FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with a model generator:
- gen_round steps 0..10 over 11 consecutive gen_en cycles;
- sched_ready rises after 11 captures.
REQ-037 Run with key_out_ready tied high:
- keys emerge on 11 consecutive cycles;
- first key_out = d014f9a8c9ee2589e13f0cc8b6630ca6 (round 10), last = 2b7e1516... (round 0);
- one done pulse follows.
REQ-038 Backpressure: deassert key_out_ready for 3 cycles at round 7; round-7 key and index SHALL stay stable, with no skip and no duplicate.
REQ-039 Second run without load SHALL replay an identical 11-key sequence; load and run asserted together in READY SHALL start FILL.
REQ-040 Assert rst low during DRAIN at round 5: all outputs are 0 next cycle; run afterwards is ignored until a new load completes.
REQ-041 With RKS_EQ_INV_CIPHER_EN defined:
- round-9 output SHALL equal InvMixColumns(ac7766f319fadc2128d12941575c006e);
- rounds 10 and 0 are unchanged.
